// File: rtl/nearest_scaler_stream.sv
// Nearest-neighbour video scaler: line-buffered input stream, fixed-point
// source stepping, 2-stage buffer read into a 4-entry output FIFO.
module nearest_scaler_stream #(
  parameter int DW = 8,
  parameter int CH = 2,
  parameter int WW = 11,
  parameter int LB = 2,
  parameter int FW = 16
) (
  input  logic             clk_in1,
  input  logic             rst,
  input  logic [WW-1:0]    src_img_width,
  input  logic [WW-1:0]    src_img_height,
  input  logic [WW-1:0]    dst_img_width,
  input  logic [WW-1:0]    dst_img_height,
  input  logic [WW+FW-1:0] x_ratio,
  input  logic [WW+FW-1:0] y_ratio,
  input  logic             round_en,
  input  logic             per_img_vsync,
  input  logic             per_img_de,
  input  logic [DW*CH-1:0] per_img_data,
  output logic             per_img_ready,
  output logic             post_img_vsync,
  output logic             post_img_de,
  output logic [DW*CH-1:0] post_img_data,
  input  logic             post_img_ready,
  output logic             ovf_err
);
  localparam int PW     = DW*CH;
  localparam int AW     = WW+FW;
  localparam int MW     = LB+WW;
  localparam int STAGES = 2;
  localparam logic [AW:0] HALF   = (AW+1)'(1) << (FW-1);
  localparam logic [WW:0] LDEPTH = (WW+1)'(1) << LB;

  typedef enum logic [1:0] {IDLE, WAIT, LINE, NEXT} st_t;

  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AW] ? '1 : s[AW-1:0];
  endfunction

  function automatic logic [WW-1:0] src_idx(input logic [AW-1:0] acc, input logic [WW-1:0] lim,
                                            input logic rnd);
    logic [AW:0] s;
    logic [WW:0] i;
    s = {1'b0, acc} + (rnd ? HALF : '0);
    i = s[AW:FW];
    return (i > {1'b0, lim} - 1'b1) ? lim - 1'b1 : i[WW-1:0];
  endfunction

  // ---------------- write side ----------------
  logic          vs_d, de_d, drop_q, drop_now, wr_en, vs_rise, de_rise;
  logic [WW-1:0] col, rows, src_x, src_y;
  logic [WW:0]   lag;

  assign vs_rise  = per_img_vsync & ~vs_d;
  assign de_rise  = per_img_de & ~de_d;
  assign drop_now = de_rise ? ~per_img_ready : drop_q;
  assign wr_en    = per_img_vsync & per_img_de & ~drop_now;

  // Signed lag: a reader that skipped ahead of the writer never blocks it.
  assign lag           = {1'b0, rows} - {1'b0, src_y};
  assign per_img_ready = rst | lag[WW] | (lag < LDEPTH);

  // vs_d resets high so a vsync already high at release is not seen as a new frame.
  always_ff @(posedge clk_in1) begin
    if (rst) begin
      vs_d    <= 1'b1;
      de_d    <= 1'b0;
      drop_q  <= 1'b0;
      col     <= '0;
      rows    <= '0;
      ovf_err <= 1'b0;
    end else begin
      vs_d <= per_img_vsync;
      de_d <= per_img_de;
      if (per_img_de) drop_q <= drop_now;
      if (per_img_vsync & de_rise & ~per_img_ready) ovf_err <= 1'b1;
      if (!per_img_vsync) begin
        col  <= '0;
        rows <= '0;
      end else begin
        col <= per_img_de ? col + 1'b1 : '0;
        if (~per_img_de & de_d & ~drop_q) rows <= rows + 1'b1;
      end
    end
  end

  // ---------------- line buffer (read-first) ----------------
  logic [PW-1:0] mem [2**MW];
  logic [PW-1:0] rd_q, rd_q2;
  logic [MW-1:0] wa, ra;

  assign wa = {rows[LB-1:0], col};
  assign ra = {src_y[LB-1:0], src_x};

  always_ff @(posedge clk_in1) begin
    if (wr_en) mem[wa] <= per_img_data;
    rd_q  <= mem[ra];
    rd_q2 <= rd_q;
  end

  // ---------------- read FSM ----------------
  st_t             st, st_nx;
  logic [AW-1:0]   x_acc, y_acc;
  logic [WW-1:0]   x_cnt, y_cnt;
  logic            in_done, abort, iss, iss_last, push, pop, vs_hold;
  logic [STAGES-1:0] vld_pipe, last_pipe;
  logic [2:0]      occ, pend;
  logic [1:0]      wp, rp;
  logic [PW:0]     fifo [4];

  assign src_x    = src_idx(x_acc, src_img_width, round_en);
  assign src_y    = src_idx(y_acc, src_img_height, round_en);
  assign abort    = vs_rise & (st != IDLE);
  assign pend     = occ + {2'b0, vld_pipe[0]} + {2'b0, vld_pipe[1]};
  assign iss      = (st == LINE) & (pend < 3'd4) & ~vs_rise;
  assign iss_last = iss & (x_cnt == dst_img_width - 1'b1) & (y_cnt == dst_img_height - 1'b1);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (vs_rise) st_nx = WAIT;
      WAIT: if ((rows > src_y) || in_done) st_nx = LINE;
      LINE: if (iss && (x_cnt == dst_img_width - 1'b1)) st_nx = NEXT;
      NEXT: st_nx = (y_cnt == dst_img_height - 1'b1) ? IDLE : WAIT;
      default: st_nx = IDLE;
    endcase
    if (abort) st_nx = WAIT;
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      st        <= IDLE;
      x_acc     <= '0;
      y_acc     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      in_done   <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      st        <= st_nx;
      vld_pipe  <= abort ? '0 : {vld_pipe[0], iss};
      last_pipe <= {last_pipe[0], iss_last};
      if (vs_rise) in_done <= 1'b0;
      else if ((vs_d & ~per_img_vsync) || (rows >= src_img_height)) in_done <= 1'b1;
      if (vs_rise) begin
        x_acc <= '0;
        y_acc <= '0;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (st == LINE && iss) begin
        x_acc <= sat_add(x_acc, x_ratio);
        x_cnt <= x_cnt + 1'b1;
      end else if (st == NEXT) begin
        y_acc <= sat_add(y_acc, y_ratio);
        y_cnt <= y_cnt + 1'b1;
        x_acc <= '0;
        x_cnt <= '0;
      end
    end
  end

  // ---------------- output FIFO ----------------
  // Each entry carries a last-of-frame tag so vsync can drop right after it.
  assign push = vld_pipe[STAGES-1];
  assign pop  = post_img_de & post_img_ready;

  always_ff @(posedge clk_in1) begin
    if (push) fifo[wp] <= {last_pipe[STAGES-1], rd_q2};
  end

  always_ff @(posedge clk_in1) begin
    if (rst || abort) begin
      wp      <= '0;
      rp      <= '0;
      occ     <= '0;
      vs_hold <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp      <= rp + 1'b1;
        vs_hold <= ~fifo[rp][PW];
      end
      occ <= occ + {2'b0, push} - {2'b0, pop};
    end
  end

  assign post_img_de    = (occ != 3'd0);
  assign post_img_data  = post_img_de ? fifo[rp][PW-1:0] : '0;
  assign post_img_vsync = post_img_de | vs_hold;
endmodule

// File: tb/tb_nearest_scaler_stream.sv
// Directed bench: up/down/round scaling, backpressure, abort, overrun, reset.
module tb_nearest_scaler_stream;
  logic        clk_in1 = 1'b0;
  logic        rst;
  logic [10:0] src_img_width, src_img_height, dst_img_width, dst_img_height;
  logic [26:0] x_ratio, y_ratio;
  logic        round_en, per_img_vsync, per_img_de, post_img_ready;
  logic [15:0] per_img_data;
  logic        per_img_ready, post_img_vsync, post_img_de, ovf_err;
  logic [15:0] post_img_data;
  logic        r1_ready, r1_vsync, r1_de, r1_ovf;
  logic [15:0] r1_data;

  int checks = 0;
  int failures = 0;
  int ex[8], ey[8];

  always #5 clk_in1 = ~clk_in1;

  nearest_scaler_stream u_dut (
    .clk_in1(clk_in1), .rst(rst),
    .src_img_width(src_img_width), .src_img_height(src_img_height),
    .dst_img_width(dst_img_width), .dst_img_height(dst_img_height),
    .x_ratio(x_ratio), .y_ratio(y_ratio), .round_en(round_en),
    .per_img_vsync(per_img_vsync), .per_img_de(per_img_de), .per_img_data(per_img_data),
    .per_img_ready(per_img_ready), .post_img_vsync(post_img_vsync), .post_img_de(post_img_de),
    .post_img_data(post_img_data), .post_img_ready(post_img_ready), .ovf_err(ovf_err));

  // Two-line buffer copy for the overrun case.
  nearest_scaler_stream #(.LB(1)) u_lb1 (
    .clk_in1(clk_in1), .rst(rst),
    .src_img_width(src_img_width), .src_img_height(src_img_height),
    .dst_img_width(dst_img_width), .dst_img_height(dst_img_height),
    .x_ratio(x_ratio), .y_ratio(y_ratio), .round_en(round_en),
    .per_img_vsync(per_img_vsync), .per_img_de(per_img_de), .per_img_data(per_img_data),
    .per_img_ready(r1_ready), .post_img_vsync(r1_vsync), .post_img_de(r1_de),
    .post_img_data(r1_data), .post_img_ready(post_img_ready), .ovf_err(r1_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int r, input int c);
    logic [7:0] v;
    v = 8'(r*16 + c);
    return {v, v ^ 8'h5A};
  endfunction

  task automatic cfg(input int sw, input int sh, input int dw, input int dh,
                     input int xr, input int yr, input bit rnd);
    src_img_width  = 11'(sw);
    src_img_height = 11'(sh);
    dst_img_width  = 11'(dw);
    dst_img_height = 11'(dh);
    x_ratio  = 27'(xr);
    y_ratio  = 27'(yr);
    round_en = rnd;
  endtask

  task automatic drive_line(input int r, input int w);
    for (int c = 0; c < w; c++) begin
      per_img_de   = 1'b1;
      per_img_data = pix(r, c);
      @(posedge clk_in1); #1;
    end
    per_img_de   = 1'b0;
    per_img_data = '0;
    repeat (2) begin @(posedge clk_in1); #1; end
  endtask

  task automatic drive_frame(input int sw, input int sh);
    @(posedge clk_in1); #1 per_img_vsync = 1'b1;
    @(posedge clk_in1); #1;
    for (int r = 0; r < sh; r++) begin
      int n = 0;
      while (!per_img_ready && n < 2000) begin @(posedge clk_in1); #1; n++; end
      if (n >= 2000) chk("rdy_timeout", 32'(per_img_ready), 1);
      drive_line(r, sw);
    end
  endtask

  // Expected pixel order comes from ex/ey index tables.
  task automatic collect(input int n, input int dw, input bit rnd, input bit fin);
    int got = 0, cyc = 0, vs_bad = 0;
    bit stall = 0;
    logic [15:0] held = '0;
    while (got < n && cyc < 5000) begin
      @(negedge clk_in1); cyc++;
      if (stall) chk("hold", 32'(post_img_data), 32'(held));
      if (!post_img_de && post_img_vsync && got == 0) vs_bad++;
      if (!post_img_vsync && got > 0) vs_bad++;
      if (post_img_de && post_img_ready) begin
        chk($sformatf("pix%0d", got), 32'(post_img_data), 32'(pix(ey[got/dw], ex[got%dw])));
        if (!post_img_vsync) vs_bad++;
        got++;
        stall = 0;
      end else begin
        stall = post_img_de;
        held  = post_img_data;
      end
      @(posedge clk_in1); #1;
      if (rnd) post_img_ready = 1'($urandom_range(0, 1));
      if (got == n && !fin) post_img_ready = 1'b0;
    end
    chk("count", 32'(got), 32'(n));
    chk("vs_span", 32'(vs_bad), 0);
    if (fin) begin
      @(negedge clk_in1);
      chk("vs_end", 32'(post_img_vsync), 0);
      chk("de_end", 32'(post_img_de), 0);
    end
  endtask

  task automatic run(input int sw, input int sh, input int dw, input int dh, input bit rnd);
    fork
      drive_frame(sw, sh);
      collect(dw*dh, dw, rnd, 1'b1);
    join
    post_img_ready = 1'b1;
    @(posedge clk_in1); #1 per_img_vsync = 1'b0;
    repeat (3) begin @(posedge clk_in1); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    rst = 1'b1;
    per_img_vsync = 1'b0;
    per_img_de = 1'b0;
    per_img_data = '0;
    post_img_ready = 1'b1;
    cfg(4, 4, 8, 8, 'h08000, 'h08000, 1'b0);
    repeat (3) @(posedge clk_in1);
    @(negedge clk_in1);
    chk("rst_vs", 32'(post_img_vsync), 0);
    chk("rst_de", 32'(post_img_de), 0);
    chk("rst_data", 32'(post_img_data), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_ready", 32'(per_img_ready), 1);
    @(posedge clk_in1); #1 rst = 1'b0;
    repeat (2) begin @(posedge clk_in1); #1; end

    // 2x upscale
    ex = '{0, 0, 1, 1, 2, 2, 3, 3}; ey = ex;
    cfg(4, 4, 8, 8, 'h08000, 'h08000, 1'b0);
    run(4, 4, 8, 8, 1'b0);

    // 2x downscale
    ex = '{0, 2, 4, 6, 0, 0, 0, 0}; ey = ex;
    cfg(8, 8, 4, 4, 'h20000, 'h20000, 1'b0);
    run(8, 8, 4, 4, 1'b0);

    // rounding with last index at the edge
    ex = '{0, 1, 2, 2, 0, 0, 0, 0}; ey = ex;
    cfg(3, 3, 4, 4, 'h0C000, 'h0C000, 1'b1);
    run(3, 3, 4, 4, 1'b0);

    // upscale under random backpressure
    ex = '{0, 0, 1, 1, 2, 2, 3, 3}; ey = ex;
    cfg(4, 4, 8, 8, 'h08000, 'h08000, 1'b0);
    run(4, 4, 8, 8, 1'b1);

    // abort after 20 pixels, then a clean frame
    fork
      drive_frame(4, 4);
      collect(20, 8, 1'b0, 1'b0);
    join
    @(posedge clk_in1); #1 per_img_vsync = 1'b0;
    @(posedge clk_in1); #1 per_img_vsync = 1'b1;
    @(posedge clk_in1);
    @(negedge clk_in1);
    chk("abort_vs", 32'(post_img_vsync), 0);
    chk("abort_de", 32'(post_img_de), 0);
    post_img_ready = 1'b1;
    run(4, 4, 8, 8, 1'b0);

    // overrun on the 2-line buffer with output blocked
    @(posedge clk_in1); #1 rst = 1'b1;
    repeat (2) begin @(posedge clk_in1); #1; end
    rst = 1'b0;
    post_img_ready = 1'b0;
    cfg(4, 4, 8, 8, 'h08000, 'h08000, 1'b0);
    @(posedge clk_in1); #1 per_img_vsync = 1'b1;
    @(posedge clk_in1); #1;
    drive_line(0, 4);
    drive_line(1, 4);
    chk("ovf_ready", 32'(r1_ready), 0);
    chk("ovf_pre", 32'(r1_ovf), 0);
    drive_line(2, 4);
    chk("ovf_set", 32'(r1_ovf), 1);
    chk("ovf_deep", 32'(ovf_err), 0);

    // reset mid-frame with vsync held high: no output until a fresh rising edge
    post_img_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk_in1);
    @(negedge clk_in1);
    chk("mrst_de", 32'(r1_de), 0);
    chk("mrst_ovf", 32'(r1_ovf), 0);
    @(posedge clk_in1); #1 rst = 1'b0;
    quiet = 0;
    repeat (30) begin
      @(negedge clk_in1);
      if (post_img_de || post_img_vsync || r1_de) quiet++;
    end
    chk("mrst_quiet", 32'(quiet), 0);
    @(posedge clk_in1); #1 per_img_vsync = 1'b0;
    repeat (2) begin @(posedge clk_in1); #1; end
    ex = '{0, 1, 2, 2, 0, 0, 0, 0}; ey = ex;
    cfg(3, 3, 4, 4, 'h0C000, 'h0C000, 1'b1);
    run(3, 3, 4, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
